// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: clear/ready handshake plus packed
// write and read port lanes.
interface regfile_mp_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = $clog2(DEPTH);

    logic                      clear_i;
    logic                      ready_o;
    logic [NUM_WR-1:0]         we_i;
    logic [NUM_WR*AW-1:0]      waddr_i;
    logic [NUM_WR*WIDTH-1:0]   wdata_i;
    logic [NUM_RD*AW-1:0]      raddr_i;
    logic [NUM_RD*WIDTH-1:0]   rdata_o;

    modport master (
        output clear_i,
        output we_i,
        output waddr_i,
        output wdata_i,
        output raddr_i,
        input  ready_o,
        input  rdata_o
    );

    modport slave (
        input  clear_i,
        input  we_i,
        input  waddr_i,
        input  wdata_i,
        input  raddr_i,
        output ready_o,
        output rdata_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with combinational reads, synchronous writes,
// optional hardwired-zero entry 0, optional write-to-read bypass and a zeroing sweep.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    regfile_mp_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   clr_ptr_reg, clr_ptr_next;
    logic            ready_reg;

    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic [AW-1:0]    waddr [NUM_WR];
    logic [WIDTH-1:0] wdata [NUM_WR];
    logic [NUM_WR-1:0] wr_en;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
            ready_reg   <= (state_next == ST_READY);
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        case (state_reg)
            ST_CLEAR: begin
                // A new request restarts the sweep from entry 0.
                if (bus.clear_i) begin
                    clr_ptr_next = '0;
                end else if (clr_ptr_reg == LAST_ADDR) begin
                    state_next   = ST_READY;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr_reg + 1'b1;
                end
            end
            ST_READY: begin
                if (bus.clear_i) begin
                    state_next   = ST_CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    assign bus.ready_o = ready_reg;

    // ------------------------------------------------------------------
    // Write ports
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            assign waddr[gi] = bus.waddr_i[gi*AW +: AW];
            assign wdata[gi] = bus.wdata_i[gi*WIDTH +: WIDTH];
            assign wr_en[gi] = bus.we_i[gi] && (state_reg == ST_READY)
                               && !(ZERO_REG && (waddr[gi] == '0));
        end
    endgenerate

    // Later ports overwrite earlier ones, so the highest index wins a collision.
    always_ff @(posedge clk_i) begin
        if (state_reg == ST_CLEAR) begin
            mem_reg[clr_ptr_reg] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k]) begin
                    mem_reg[waddr[k]] <= wdata[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]    raddr;
            logic [WIDTH-1:0] rd_val;

            assign raddr = bus.raddr_i[gi*AW +: AW];

            always_comb begin
                rd_val = mem_reg[raddr];
                if (BYPASS) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wr_en[k] && (waddr[k] == raddr)) begin
                            rd_val = wdata[k];
                        end
                    end
                end
                // Storage is not trustworthy until the sweep finishes.
                if (state_reg != ST_READY) begin
                    rd_val = '0;
                end else if (ZERO_REG && (raddr == '0)) begin
                    rd_val = '0;
                end
            end

            assign bus.rdata_o[gi*WIDTH +: WIDTH] = rd_val;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with default settings and one with two
// write ports, bypass enabled and an ordinary entry 0.
module tb_regfile_mp;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt;

    always #5 clk_i = ~clk_i;

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1)) bus_a ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus_b ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1),
                 .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_a (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_a)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2),
                 .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_b (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1);
        bus_a.we_i    = we;
        bus_a.waddr_i = wa;
        bus_a.wdata_i = wd;
        bus_a.raddr_i = {r1, r0};
    endtask

    task automatic set_b(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] r0, input logic [4:0] r1);
        bus_b.we_i    = we;
        bus_b.waddr_i = {wa1, wa0};
        bus_b.wdata_i = {wd1, wd0};
        bus_b.raddr_i = {r1, r0};
    endtask

    // Counts rising edges until ready_o of instance A rises; 100 means it never did.
    task automatic wait_ready_a(output int n);
        n = 0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (!bus_a.ready_o && n < 100);
    endtask

    initial begin
        bus_a.clear_i = 1'b0;
        bus_b.clear_i = 1'b0;
        set_a(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        set_b(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        #2;
        chk("rst_ready_a", {31'b0, bus_a.ready_o}, 32'd0);
        chk("rst_ready_b", {31'b0, bus_b.ready_o}, 32'd0);
        chk("rst_rdata_a", bus_a.rdata_o[31:0], 32'h0);

        // Reset release: exactly 32 busy cycles, then everything reads 0.
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_ready_a(cnt);
        chk("init_clear_len", cnt, 32'd32);
        chk("init_ready_b", {31'b0, bus_b.ready_o}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            set_a(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            set_b(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(i), 5'd0);
            #1;
            chk($sformatf("init_a0[%0d]", i), bus_a.rdata_o[31:0], 32'h0);
            chk($sformatf("init_a1[%0d]", 31 - i), bus_a.rdata_o[63:32], 32'h0);
            chk($sformatf("init_b0[%0d]", i), bus_b.rdata_o[31:0], 32'h0);
        end

        // Same-cycle read of a written address: old value without bypass, new with.
        @(negedge clk_i);
        set_a(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        set_b(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd0);
        #1;
        chk("nobyp_same", bus_a.rdata_o[31:0], 32'h0);
        chk("byp_same", bus_b.rdata_o[31:0], 32'hDEADBEEF);
        @(negedge clk_i);
        set_a(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        set_b(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5);
        #1;
        chk("nobyp_next_p0", bus_a.rdata_o[31:0], 32'hDEADBEEF);
        chk("nobyp_next_p1", bus_a.rdata_o[63:32], 32'hDEADBEEF);
        chk("byp_next", bus_b.rdata_o[63:32], 32'hDEADBEEF);

        // Two ports to one address: port 1 wins, both for bypass and storage.
        @(negedge clk_i);
        set_b(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 5'd7, 5'd7);
        #1;
        chk("collide_byp", bus_b.rdata_o[31:0], 32'h2222);
        @(negedge clk_i);
        set_b(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd5);
        #1;
        chk("collide_store", bus_b.rdata_o[31:0], 32'h2222);
        chk("collide_other", bus_b.rdata_o[63:32], 32'hDEADBEEF);

        // Two ports to different addresses: both commit.
        @(negedge clk_i);
        set_b(2'b11, 5'd8, 32'h88, 5'd9, 32'h99, 5'd8, 5'd9);
        #1;
        chk("dual_byp_p0", bus_b.rdata_o[31:0], 32'h88);
        chk("dual_byp_p1", bus_b.rdata_o[63:32], 32'h99);
        @(negedge clk_i);
        set_b(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd8);
        #1;
        chk("dual_store_p0", bus_b.rdata_o[31:0], 32'h99);
        chk("dual_store_p1", bus_b.rdata_o[63:32], 32'h88);

        // Entry 0: hardwired zero on A, ordinary register on B.
        @(negedge clk_i);
        set_a(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        set_b(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd0, 5'd5);
        #1;
        chk("zero_same_p0", bus_a.rdata_o[31:0], 32'h0);
        chk("zero_same_p1", bus_a.rdata_o[63:32], 32'h0);
        chk("r0_byp", bus_b.rdata_o[31:0], 32'hFFFFFFFF);
        @(negedge clk_i);
        set_a(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        set_b(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd5);
        #1;
        chk("zero_next_p0", bus_a.rdata_o[31:0], 32'h0);
        chk("zero_next_p1", bus_a.rdata_o[63:32], 32'h0);
        chk("r0_store", bus_b.rdata_o[31:0], 32'hFFFFFFFF);
        chk("r5_kept", bus_b.rdata_o[63:32], 32'hDEADBEEF);

        // Clear request in READY; writes during the sweep are ignored.
        @(negedge clk_i);
        set_a(1'b1, 5'd3, 32'hA5, 5'd3, 5'd0);
        @(negedge clk_i);
        set_a(1'b0, 5'd0, 32'h0, 5'd3, 5'd10);
        #1;
        chk("pre_clear_r3", bus_a.rdata_o[31:0], 32'hA5);
        @(negedge clk_i);
        bus_a.clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus_a.clear_i = 1'b0;
        set_a(1'b1, 5'd10, 32'h77, 5'd3, 5'd10);
        #1;
        chk("clear_ready_low", {31'b0, bus_a.ready_o}, 32'd0);
        chk("clear_rdata_zero", bus_a.rdata_o[31:0], 32'h0);
        wait_ready_a(cnt);
        chk("clear_len", cnt, 32'd32);
        set_a(1'b0, 5'd0, 32'h0, 5'd3, 5'd10);
        #1;
        chk("post_clear_r3", bus_a.rdata_o[31:0], 32'h0);
        chk("post_clear_r10", bus_a.rdata_o[63:32], 32'h0);

        // Second pulse mid-sweep restarts the 32-cycle window.
        @(negedge clk_i);
        bus_a.clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus_a.clear_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        chk("restart_mid_busy", {31'b0, bus_a.ready_o}, 32'd0);
        @(negedge clk_i);
        bus_a.clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus_a.clear_i = 1'b0;
        wait_ready_a(cnt);
        chk("restart_len", cnt, 32'd32);

        // Fill A with garbage, then hit reset mid-cycle.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk_i);
            set_a(1'b1, 5'(i), 32'hC0DE0000 | i, 5'd0, 5'd0);
        end
        @(negedge clk_i);
        set_a(1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
        #1;
        chk("garbage_r9", bus_a.rdata_o[31:0], 32'hC0DE0009);
        chk("garbage_r31", bus_a.rdata_o[63:32], 32'hC0DE001F);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_ready_a", {31'b0, bus_a.ready_o}, 32'd0);
        chk("async_rdata_a", bus_a.rdata_o[31:0], 32'h0);
        chk("async_ready_b", {31'b0, bus_b.ready_o}, 32'd0);
        set_a(1'b1, 5'd9, 32'h12345678, 5'd9, 5'd31);
        @(posedge clk_i);
        #1;
        chk("rst_write_lost", dut_a.mem_reg[9], 32'hC0DE0009);
        @(negedge clk_i);
        rst_i = 1'b0;
        set_a(1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
        wait_ready_a(cnt);
        chk("rerst_clear_len", cnt, 32'd32);
        for (int i = 0; i < 32; i++) begin
            set_a(1'b0, 5'd0, 32'h0, 5'(i), 5'd0);
            #1;
            chk($sformatf("rerst_a0[%0d]", i), bus_a.rdata_o[31:0], 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
